// File: rtl/hex_display_scheduler.sv
// Four-digit seven-segment scan controller shared between the PIO value and a
// hardware source that borrows the display for a fixed number of frames.
module hex_display_scheduler #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int HOLD_FRAMES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pio_value,
  input  logic        hw_req,
  input  logic [15:0] hw_value,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic [3:0]  dig_n,
  output logic        src_hw,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    digit, digit_nx;
  logic [CW-1:0] slot, slot_nx;

  logic          pending;
  logic [15:0]   hw_latch;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_dec;
  logic [15:0]   snap;
  logic [3:0]    blank;

  logic          sel_hw;
  logic [15:0]   load_val;
  logic [3:0]    load_blank;

  logic [6:0]    seg_d;
  logic [3:0]    dig_d;
  logic          tick_d;

  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      default: f = 7'h0E;
    endcase
    return f;
  endfunction

  // State register: the slot counter restarts at every transition, so the
  // frame period is exact and cannot drift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
      digit <= 2'd0;
      slot  <= '0;
    end else begin
      state <= state_nx;
      digit <= digit_nx;
      slot  <= slot_nx;
    end
  end

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    slot_nx  = slot + 1'b1;
    case (state)
      S_LOAD: begin
        state_nx = S_DRIVE;
        digit_nx = 2'd0;
        slot_nx  = '0;
      end
      S_DRIVE: begin
        if (slot == DRIVE_LAST) begin
          state_nx = S_GAP;
          slot_nx  = '0;
        end
      end
      S_GAP: begin
        if (slot == GAP_LAST) begin
          slot_nx = '0;
          if (digit == 2'd3) begin
            state_nx = S_LOAD;
          end else begin
            state_nx = S_DRIVE;
            digit_nx = digit + 2'd1;
          end
        end
      end
      default: begin
        state_nx = S_LOAD;
        slot_nx  = '0;
      end
    endcase
  end

  // Source selection for the frame being loaded. A pending request always
  // restarts the hold; otherwise the hold runs down one frame per LOAD.
  always_comb begin
    hold_dec = hold - 1'b1;
    if (pending) begin
      sel_hw = 1'b1;
    end else if (hold != '0) begin
      sel_hw = (hold_dec != '0);
    end else begin
      sel_hw = 1'b0;
    end
    load_val      = sel_hw ? hw_latch : pio_value;
    load_blank[0] = 1'b0;
    load_blank[1] = blank_lz & (load_val[15:4] == 12'h000);
    load_blank[2] = blank_lz & (load_val[15:8] == 8'h00);
    load_blank[3] = blank_lz & (load_val[15:12] == 4'h0);
  end

  // hw_req is a single-cycle strobe with no back-pressure: the value is
  // captured on the cycle it is high and a newer strobe simply overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      hw_latch <= '0;
      hold     <= '0;
      snap     <= '0;
      blank    <= '0;
      src_hw   <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        if (pending) begin
          hold <= HOLD_INIT;
        end else if (hold != '0) begin
          hold <= hold_dec;
        end
        snap   <= load_val;
        blank  <= load_blank;
        src_hw <= sel_hw;
      end
      if (hw_req) begin
        pending  <= 1'b1;
        hw_latch <= hw_value;
      end else if (state == S_LOAD) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    seg_d  = 7'h7F;
    dig_d  = 4'hF;
    tick_d = 1'b0;
    case (state)
      S_LOAD: tick_d = 1'b1;
      S_DRIVE: begin
        dig_d = ~(4'b0001 << digit);
        seg_d = blank[digit] ? 7'h7F : font(snap[{digit, 2'b00} +: 4]);
      end
      default: begin
        seg_d  = 7'h7F;
        dig_d  = 4'hF;
        tick_d = 1'b0;
      end
    endcase
  end

  // Output stage: pins show the decoded FSM state one cycle later, so
  // digit 0 lights the cycle after the frame_tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n      <= 7'h7F;
      dig_n      <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dig_n      <= dig_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler: frame-level reference model with an
// expected-output queue, directed scenarios and randomized traffic.
module tb_hex_display_scheduler;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int HOLD     = 2;
  localparam int FRAME    = 4 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pio_value;
  logic        hw_req;
  logic [15:0] hw_value;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        src_hw;
  logic        frame_tick;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .pio_value(pio_value), .hw_req(hw_req),
    .hw_value(hw_value), .blank_lz(blank_lz), .seg_n(seg_n), .dig_n(dig_n),
    .src_hw(src_hw), .frame_tick(frame_tick)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position within the frame plus frame-level ownership.
  int          m_pos = -1;
  bit          m_pending;
  logic [15:0] m_latch;
  logic [15:0] m_snap;
  int          m_frames_left;
  bit          m_lz;
  bit          m_src;

  logic [12:0] exp_q[$];
  logic [12:0] got;
  logic [12:0] exp;

  task automatic step();
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic [15:0] sh;
    int          j;
    int          k;
    @(posedge clk);
    if (reset) begin
      m_pos = -1;
      m_pending = 0;
      m_frames_left = 0;
      m_src = 0;
      m_latch = '0;
    end else begin
      m_pos = (m_pos < 0 || m_pos == FRAME - 1) ? 0 : m_pos + 1;
      if (m_pos == 0) begin
        if (m_pending) begin
          m_frames_left = HOLD;
          m_pending = 0;
        end
        if (m_frames_left > 0) begin
          m_snap = m_latch;
          m_src = 1;
          m_frames_left--;
        end else begin
          m_snap = pio_value;
          m_src = 0;
        end
        m_lz = blank_lz;
      end
      if (hw_req) begin
        m_pending = 1;
        m_latch = hw_value;
      end
    end
    e_seg = 7'h7F;
    e_dig = 4'hF;
    if (m_pos > 0) begin
      j = m_pos - 1;
      k = j / SCAN_DIV;
      if ((j % SCAN_DIV) < SCAN_DIV - BLANK) begin
        e_dig = 4'hF ^ (4'b0001 << k);
        sh = m_snap >> (4 * k);
        if (!(m_lz && k > 0 && sh == 16'h0000)) e_seg = font_tab[sh[3:0]];
      end
    end
    exp_q.push_back({e_seg, e_dig, (m_pos >= 0) ? m_src : 1'b0, m_pos == 0});
    #1;
  endtask

  task automatic test_reset();
    reset = 1; pio_value = 16'h1A2F; hw_req = 0; hw_value = '0; blank_lz = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== 13'h1FFC || got !== exp) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got seg=%h dig=%b src=%b tick=%b expected seg=7f dig=1111 src=0 tick=0",
                 i, got[12:6], got[5:2], got[1], got[0]);
      end
    end
  endtask

  task automatic test_frame_scan();
    reset = 0;
    for (int i = 0; i < 2 * FRAME + 3; i++) begin
      step();
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL frame_scan pos=%0d got seg=%h dig=%b src=%b tick=%b expected seg=%h dig=%b src=%b tick=%b",
                 m_pos, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_blanking();
    pio_value = 16'h0040; blank_lz = 1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (i == 2 * FRAME) pio_value = 16'h0000;
      step();
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL blanking pio=%h pos=%0d got seg=%h dig=%b expected seg=%h dig=%b",
                 pio_value, m_pos, got[12:6], got[5:2], exp[12:6], exp[5:2]);
      end
    end
    blank_lz = 0;
  endtask

  task automatic test_hw_hold();
    pio_value = 16'h1234;
    for (int i = 0; i < 2 * FRAME && m_pos != 10; i++) step();
    if (m_pos != 10) begin
      miscompares++;
      $display("FAIL hw_hold_sync pos=%0d required 10", m_pos);
    end
    exp_q.delete();
    hw_value = 16'h00FF; hw_req = 1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      hw_req = 0; hw_value = 16'h5555;
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hw_hold pos=%0d got seg=%h dig=%b src=%b tick=%b expected seg=%h dig=%b src=%b tick=%b",
                 m_pos, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_req_in_load();
    for (int i = 0; i < 2 * FRAME && m_pos != 0; i++) step();
    if (m_pos != 0) begin
      miscompares++;
      $display("FAIL req_in_load_sync pos=%0d required 0", m_pos);
    end
    exp_q.delete();
    hw_value = 16'hABCD; hw_req = 1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      step();
      hw_req = 0;
      if (i == FRAME + 12) begin
        hw_value = 16'hBEEF; hw_req = 1;
      end
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL req_in_load pos=%0d got seg=%h dig=%b src=%b tick=%b expected seg=%h dig=%b src=%b tick=%b",
                 m_pos, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_pio_midframe();
    pio_value = 16'h9876;
    for (int i = 0; i < 2 * FRAME && m_pos != 10; i++) step();
    if (m_pos != 10) begin
      miscompares++;
      $display("FAIL pio_midframe_sync pos=%0d required 10", m_pos);
    end
    exp_q.delete();
    pio_value = 16'hC0DE;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pio_midframe pos=%0d got seg=%h dig=%b expected seg=%h dig=%b",
                 m_pos, got[12:6], got[5:2], exp[12:6], exp[5:2]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    hw_value = 16'h0F0F; hw_req = 1;
    step();
    hw_req = 0;
    for (int i = 0; i < 3 * FRAME && !(m_src && m_pos == 19); i++) step();
    if (!(m_src && m_pos == 19)) begin
      miscompares++;
      $display("FAIL reset_midframe_sync pos=%0d src=%0d required 19 and 1", m_pos, m_src);
    end
    exp_q.delete();
    reset = 1;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      reset = 0;
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_midframe pos=%0d got seg=%h dig=%b src=%b tick=%b expected seg=%h dig=%b src=%b tick=%b",
                 m_pos, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FRAME; i++) begin
      hw_req = ($urandom_range(0, 19) == 0);
      hw_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 39) == 0)
        pio_value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
      if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
      step();
      exp = exp_q.pop_front(); got = {seg_n, dig_n, src_hw, frame_tick}; vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random pos=%0d got seg=%h dig=%b src=%b tick=%b expected seg=%h dig=%b src=%b tick=%b",
                 m_pos, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
      end
    end
    hw_req = 0;
  endtask

  initial begin
    test_reset();
    test_frame_scan();
    test_blanking();
    test_hw_hold();
    test_req_in_load();
    test_pio_midframe();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
